im_fetch_ctrl: RTL
==================

Name: im_fetch_ctrl

Overview:
- Instruction-fetch sequencer for the 1024x16 instruction ROM (combinational read: data valid same cycle as address).
- Owns the program counter, drives the ROM address and buffers fetched words in a 2-entry queue.
- Presents instructions to decode over a valid/ready handshake; handles branch redirect, run/stop and halt-opcode detection.

Parameters:
- AW, 10, ROM address width; PC wraps modulo 2^AW.
- DW, 16, instruction width.
- RESET_PC, 0, PC value after reset.
- HALT_OP, 4'hF, opcode (instr[DW-1:DW-4]) that halts fetching.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- run_en  in  1  level: 1 = fetching permitted.
- im_addr  out  AW  ROM address, equals PC register.
- im_data  in  DW  ROM read data for im_addr, same cycle.
- redirect_valid  in  1  one-cycle branch/jump request.
- redirect_pc  in  AW  target address, sampled with redirect_valid.
- instr_valid  out  1  queue head valid.
- instr_ready  in  1  decode accepts head.
- instr  out  DW  queue head instruction.
- instr_pc  out  AW  address of instr.
- halt  out  1  halted status.

Behaviour:
- Reset (rst=0, async): pc=RESET_PC, queue empty, instr_valid=0, instr=0, instr_pc=0, halt=0, state=IDLE. All outputs registered except im_addr (= pc).
- States: IDLE, RUN, HALT.
- IDLE: no fetch. run_en=1 -> RUN next edge. redirect_valid loads pc, stays IDLE.
- RUN: fetch occurs in a cycle when queue count<2, or count==2 and a pop happens that cycle. Fetch = push {im_data, pc}, pc <= pc+1 (AW bits, 2^AW-1 wraps to 0). run_en=0 -> IDLE next edge, with no fetch in that cycle; the queue still drains.
- Latency: run_en rises in cycle N (IDLE) -> RUN at N+1 -> first fetch in N+1 -> instr_valid=1 in N+2. Sustained throughput 1 instr/cycle while instr_ready=1.
- Pop: instr_valid & instr_ready. Head and valid hold stable while instr_ready=0.
- Halt: a fetched word whose opcode==HALT_OP is pushed, then fetching stops; pc holds at halt address+1. When that word is popped -> HALT, halt=1. HALT: no fetch, run_en ignored.
- Redirect (any state): queue flushed, pc <= redirect_pc, no push that cycle. instr_valid=0 next cycle. RUN: word at redirect_pc appears at N+2. HALT: -> RUN, halt=0. Pending halt cleared.
- Simultaneous redirect + pop: the pop counts as accepted, then flush. Redirect wins over halt entry and over run_en=0; next state is RUN if run_en=1, else IDLE.
- Reset mid-operation: immediate return to reset values; no partial push.

Optional Feature:
- Macro: IM_FETCH_PERF_EN.
- Defined: adds outputs perf_fetch (16 bits) and perf_stall (16 bits), both reset to 0 and saturating at 16'hFFFF. perf_fetch increments per push. perf_stall increments per cycle in RUN with instr_valid=1 & instr_ready=0.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package im_fetch_pkg: state enum (IDLE/RUN/HALT), AW/DW defaults, HALT_OP, queue entry typedef {instr, pc}.
- Sub-module fetch_fifo2: 2-entry FIFO with push/pop/flush, count, and same-cycle push+pop when full. Controller holds pc, FSM and halt logic.

Test Plan:
- Reset, run_en=1, ROM[k]=16'h1000+k, instr_ready=1 -> instr 16'h1000,1001,1002 with instr_pc 0,1,2 on consecutive cycles from cycle 2.
- instr_ready=0 for 5 cycles -> queue fills to 2, im_addr frozen at 2, instr stays 16'h1000. Release -> 1000,1001,1002, no gaps or duplicates.
- Redirect to 10'h3FE with ROM[3FE]=16'hA000 -> instr_valid=0 for 1 cycle, then instr_pc 3FE, 3FF, 000 (wrap).
- ROM[5]=16'hF000 -> instructions 0..5 delivered, halt=1 after pop of pc 5, im_addr=6 held. Redirect to 0 -> halt=0, fetch resumes.
- Redirect asserted same cycle as a pop with full queue -> popped word consumed once, other entry discarded, next instr is the target word.
- Assert rst mid-stream -> instr_valid, halt and queue clear immediately, im_addr=RESET_PC.

Source files
------------

// File: rtl/im_fetch_pkg.sv
// im_fetch_pkg: shared types and defaults for the instruction-fetch sequencer
package im_fetch_pkg;
  localparam int AW_DEF = 10;
  localparam int DW_DEF = 16;
  localparam logic [3:0] HALT_OP_DEF = 4'hF;
  typedef enum logic [1:0] {IDLE, RUN, HALT} state_e;
  typedef struct packed {
    logic [DW_DEF-1:0] instr;
    logic [AW_DEF-1:0] pc;
  } entry_t;
endpackage

// File: rtl/im_fetch_ctrl_fifo.sv
// fetch_fifo2: 2-entry FIFO with flush, registered head, push+pop allowed when full
module fetch_fifo2 #(
  parameter int W = 26
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         valid,
  output logic [1:0]   count
);
  logic [W-1:0] e0_q, e0_d, e1_q, e1_d;
  logic [1:0]   cnt_q, cnt_d;
  // next contents: flush drops everything, otherwise shift on pop and append on push
  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    cnt_d = cnt_q;
    if (flush) cnt_d = 2'd0;
    else if (push && pop) begin
      e0_d = (cnt_q == 2'd2) ? e1_q : din;
      e1_d = din;
    end else if (pop) begin
      e0_d  = e1_q;
      cnt_d = cnt_q - 2'd1;
    end else if (push) begin
      if (cnt_q == 2'd0) e0_d = din;
      else e1_d = din;
      cnt_d = cnt_q + 2'd1;
    end
  end
  // storage registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= 2'd0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      cnt_q <= cnt_d;
    end
  end
  assign head  = e0_q;
  assign valid = cnt_q != 2'd0;
  assign count = cnt_q;
endmodule

// File: rtl/im_fetch_ctrl.sv
// im_fetch_ctrl: PC/FSM/halt control feeding a 2-entry instruction queue; IM_FETCH_PERF_EN adds perf counters
module im_fetch_ctrl
  import im_fetch_pkg::*;
#(
  parameter int          AW       = AW_DEF,
  parameter int          DW       = DW_DEF,
  parameter logic [AW-1:0] RESET_PC = '0,
  parameter logic [3:0]  HALT_OP  = HALT_OP_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run_en,
  output logic [AW-1:0] im_addr,
  input  logic [DW-1:0] im_data,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [DW-1:0] instr,
  output logic [AW-1:0] instr_pc,
  output logic          halt
`ifdef IM_FETCH_PERF_EN
  ,
  output logic [15:0]   perf_fetch,
  output logic [15:0]   perf_stall
`endif
);
  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          hpend_q, hpend_d;
  logic          pop, push, halt_pop;
  logic [1:0]    count;
  logic [DW+AW-1:0] head;
  fetch_fifo2 #(.W(DW+AW)) u_fifo (
    .clk  (clk),
    .rst_n(rst),
    .push (push),
    .pop  (pop),
    .flush(redirect_valid),
    .din  ({im_data, pc_q}),
    .head (head),
    .valid(instr_valid),
    .count(count)
  );
  assign {instr, instr_pc} = head;
  assign im_addr = pc_q;
  assign halt    = state_q == HALT;
  assign pop     = instr_valid && instr_ready;
  // state, pc and pending-halt registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      hpend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hpend_q <= hpend_d;
    end
  end
  // next state: redirect beats halt entry; HALT is sticky until a redirect
  always_comb begin
    state_d = redirect_valid ? (run_en ? RUN : IDLE) :
              halt_pop ? HALT :
              (state_q == HALT) ? HALT :
              run_en ? RUN : IDLE;
  end
  // fetch decision, pc update and halt tracking; the halt word is always the last queued
  always_comb begin
    push     = state_q == RUN && run_en && !hpend_q && !redirect_valid && (count != 2'd2 || pop);
    halt_pop = pop && hpend_q && count == 2'd1;
    pc_d     = redirect_valid ? redirect_pc : push ? pc_q + 1'b1 : pc_q;
    hpend_d  = redirect_valid ? 1'b0 :
               (push && im_data[DW-1 -: 4] == HALT_OP) ? 1'b1 :
               halt_pop ? 1'b0 : hpend_q;
  end
`ifdef IM_FETCH_PERF_EN
  logic [15:0] pf_q, ps_q;
  // saturating fetch and stall counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pf_q <= '0;
      ps_q <= '0;
    end else begin
      pf_q <= (push && pf_q != 16'hFFFF) ? pf_q + 16'd1 : pf_q;
      ps_q <= (state_q == RUN && instr_valid && !instr_ready && ps_q != 16'hFFFF) ? ps_q + 16'd1 : ps_q;
    end
  end
  assign perf_fetch = pf_q;
  assign perf_stall = ps_q;
`endif
endmodule
